state_dump_unit: RTL and testbench

STATE_DUMP_UNIT -- requirements
Module: state_dump_unit

---
 rtl/state_dump_unit.sv | 207 ++++++++++++++++++++
 tb/tb_state_dump_unit.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/state_dump_unit.sv
`timescale 1ns/1ps
// state_dump_unit: streams the GPR file and/or a window of data memory out
// as tagged beats over a valid/ready interface.
//
// Ports:
//   clk, rst (async, active-low)
//   start, sel[1:0], mem_base, mem_count   dump request (sampled when idle)
//   busy, done                             progress / one-cycle completion pulse
//   reg_re, reg_raddr, reg_rdata           GPR read port (data one cycle after strobe)
//   mem_re, mem_raddr, mem_rdata           memory read port (data one cycle after strobe)
//   out_valid, out_ready, out_src,
//   out_idx, out_data                      dump stream (src 0=GPR, 1=memory)
//
// Read strobes are decoded from the state and the buffer credit in the same
// cycle. Counting this cycle's pop and returning word is what lets a
// 2-entry buffer sustain one beat per cycle without ever overflowing.
module state_dump_unit #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned MEM_DEPTH = 32,
    localparam int unsigned RAW   = $clog2(NUM_REGS),
    localparam int unsigned MAW   = $clog2(MEM_DEPTH),
    localparam int unsigned IDX_W = (RAW > MAW) ? RAW : MAW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        sel,
    input  logic [MAW-1:0]    mem_base,
    input  logic [MAW:0]      mem_count,
    output logic              busy,
    output logic              done,
    output logic              reg_re,
    output logic [RAW-1:0]    reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              mem_re,
    output logic [MAW-1:0]    mem_raddr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_src,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_data
);

    localparam int unsigned CW = MAW + 1;
    localparam logic [CW-1:0]  DEPTH_C    = CW'(MEM_DEPTH);
    localparam logic [RAW-1:0] LAST_REG_C = RAW'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, REGS, MEM, DRAIN} state_t;

    state_t             state;
    logic               sel_mem;
    logic [CW-1:0]      cnt;
    logic [RAW-1:0]     reg_idx;
    logic [MAW-1:0]     mem_addr;

    // read whose data returns this cycle
    logic               pend;
    logic               pend_src;
    logic [IDX_W-1:0]   pend_idx;

    // buffer: head lives in the out_* registers, e1 is the second entry
    logic [1:0]         occ;
    logic               e1_src;
    logic [IDX_W-1:0]   e1_idx;
    logic [DATA_W-1:0]  e1_data;

    logic               pop;
    logic [2:0]         level;
    logic               credit_ok;
    logic [CW-1:0]      cnt_clamp;
    logic [DATA_W-1:0]  push_data;
    logic               last_reg;
    logic               regs_to_mem;

    // occupancy after this edge, excluding any read issued now
    assign pop       = out_valid & out_ready;
    assign level     = 3'(occ) + 3'(pend) - 3'(pop);
    assign credit_ok = (level < 3'd2);

    assign reg_re    = (state == REGS) && credit_ok;
    assign mem_re    = (state == MEM)  && credit_ok;
    assign reg_raddr = reg_idx;
    assign mem_raddr = mem_addr;

    assign cnt_clamp   = (mem_count > DEPTH_C) ? DEPTH_C : mem_count;
    assign push_data   = pend_src ? mem_rdata : reg_rdata;
    assign last_reg    = (reg_idx == LAST_REG_C);
    assign regs_to_mem = sel_mem && (cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sel_mem   <= 1'b0;
            cnt       <= '0;
            reg_idx   <= '0;
            mem_addr  <= '0;
            pend      <= 1'b0;
            pend_src  <= 1'b0;
            pend_idx  <= '0;
            occ       <= 2'd0;
            e1_src    <= 1'b0;
            e1_idx    <= '0;
            e1_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_src   <= 1'b0;
            out_idx   <= '0;
            out_data  <= '0;
        end else begin
            done <= 1'b0;

            // read-return pipeline stage
            pend     <= reg_re | mem_re;
            pend_src <= mem_re;
            pend_idx <= mem_re ? IDX_W'(mem_addr) : IDX_W'(reg_idx);

            // two-entry buffer: push returning word, pop on handshake
            case ({pend, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        out_src   <= pend_src;
                        out_idx   <= pend_idx;
                        out_data  <= push_data;
                        out_valid <= 1'b1;
                    end else begin
                        e1_src  <= pend_src;
                        e1_idx  <= pend_idx;
                        e1_data <= push_data;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    out_src   <= e1_src;
                    out_idx   <= e1_idx;
                    out_data  <= e1_data;
                    out_valid <= (occ == 2'd2);
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        out_src  <= pend_src;
                        out_idx  <= pend_idx;
                        out_data <= push_data;
                    end else begin
                        out_src  <= e1_src;
                        out_idx  <= e1_idx;
                        out_data <= e1_data;
                        e1_src   <= pend_src;
                        e1_idx   <= pend_idx;
                        e1_data  <= push_data;
                    end
                end
                default: ;
            endcase

            // sequencing
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    // busy is still high on the done cycle, so a start there is ignored
                    if (start && !busy) begin
                        busy     <= 1'b1;
                        sel_mem  <= sel[1];
                        cnt      <= cnt_clamp;
                        mem_addr <= mem_base;
                        reg_idx  <= '0;
                        if (sel[0])
                            state <= REGS;
                        else if (sel[1] && (cnt_clamp != '0))
                            state <= MEM;
                        else
                            state <= DRAIN;
                    end
                end
                REGS: begin
                    if (reg_re) begin
                        reg_idx <= reg_idx + RAW'(1);
                        if (last_reg)
                            state <= regs_to_mem ? MEM : DRAIN;
                    end
                end
                MEM: begin
                    if (mem_re) begin
                        mem_addr <= mem_addr + MAW'(1);
                        cnt      <= cnt - CW'(1);
                        if (cnt == CW'(1))
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // finish once the buffer empties at this edge with nothing returning
                    if (level == 3'd0) begin
                        done     <= 1'b1;
                        state    <= IDLE;
                        reg_idx  <= '0;
                        mem_addr <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_state_dump_unit.sv
`timescale 1ns/1ps
// Testbench for state_dump_unit: default instance (32 GPRs, 32 memory words)
// plus a resized instance (8 GPRs, 64 memory words, 16-bit data).
module tb_state_dump_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    always @(posedge clk) cyc++;

    typedef struct packed {
        logic        src;
        logic [5:0]  idx;
        logic [31:0] data;
    } beat_t;

    beat_t qa[$];
    beat_t qb[$];

    // instance A: defaults
    logic        a_start, a_busy, a_done, a_reg_re, a_mem_re;
    logic [1:0]  a_sel;
    logic [4:0]  a_base, a_reg_raddr, a_mem_raddr, a_out_idx;
    logic [5:0]  a_count;
    logic [31:0] a_reg_rdata, a_mem_rdata, a_out_data;
    logic        a_out_valid, a_out_src;
    logic        a_out_ready = 1'b1;

    // instance B: resized
    logic        b_start, b_busy, b_done, b_reg_re, b_mem_re;
    logic [1:0]  b_sel;
    logic [5:0]  b_base, b_mem_raddr, b_out_idx;
    logic [2:0]  b_reg_raddr;
    logic [6:0]  b_count;
    logic [15:0] b_reg_rdata, b_mem_rdata, b_out_data;
    logic        b_out_valid, b_out_src;
    logic        b_out_ready = 1'b1;

    state_dump_unit #(.DATA_W(32), .NUM_REGS(32), .MEM_DEPTH(32)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .sel(a_sel),
        .mem_base(a_base), .mem_count(a_count), .busy(a_busy), .done(a_done),
        .reg_re(a_reg_re), .reg_raddr(a_reg_raddr), .reg_rdata(a_reg_rdata),
        .mem_re(a_mem_re), .mem_raddr(a_mem_raddr), .mem_rdata(a_mem_rdata),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_src(a_out_src),
        .out_idx(a_out_idx), .out_data(a_out_data)
    );

    state_dump_unit #(.DATA_W(16), .NUM_REGS(8), .MEM_DEPTH(64)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .sel(b_sel),
        .mem_base(b_base), .mem_count(b_count), .busy(b_busy), .done(b_done),
        .reg_re(b_reg_re), .reg_raddr(b_reg_raddr), .reg_rdata(b_reg_rdata),
        .mem_re(b_mem_re), .mem_raddr(b_mem_raddr), .mem_rdata(b_mem_rdata),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_src(b_out_src),
        .out_idx(b_out_idx), .out_data(b_out_data)
    );

    // storage models: GPR[i]=i*3, mem[i]=100+i, garbage when not strobed
    always @(posedge clk) begin
        a_reg_rdata <= a_reg_re ? 32'(a_reg_raddr) * 32'd3 : 32'hdead_beef;
        a_mem_rdata <= a_mem_re ? 32'd100 + 32'(a_mem_raddr) : 32'hbad0_bad0;
        b_reg_rdata <= b_reg_re ? 16'(b_reg_raddr) * 16'd3 : 16'hdead;
        b_mem_rdata <= b_mem_re ? 16'd100 + 16'(b_mem_raddr) : 16'hbad0;
    end

    // out_ready pattern 1,0,0,1 while a_toggle is set
    bit a_toggle = 1'b0;
    int a_ph = 0;
    always @(posedge clk) begin
        #1;
        if (a_toggle) begin
            a_out_ready = (a_ph == 0) || (a_ph == 3);
            a_ph = (a_ph + 1) % 4;
        end else begin
            a_out_ready = 1'b1;
            a_ph = 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // stream monitors: every valid cycle must show the scoreboard head
    int a_beats = 0, a_dones = 0, a_first_cyc = 0, a_last_cyc = 0, a_done_cyc = 0, a_mark = 0;
    int b_beats = 0, b_dones = 0;

    always @(negedge clk) begin
        if (rst) begin
            if (a_reg_re | a_mem_re)
                check("a_one_strobe", 64'(a_reg_re & a_mem_re), 64'(0));
            if (a_out_valid) begin
                check("a_beat_expected", 64'(qa.size() != 0), 64'(1));
                if (qa.size() != 0) begin
                    check("a_src",  64'(a_out_src),  64'(qa[0].src));
                    check("a_idx",  64'(a_out_idx),  64'(qa[0].idx));
                    check("a_data", 64'(a_out_data), 64'(qa[0].data));
                end
                if (a_out_ready) begin
                    if (qa.size() != 0) void'(qa.pop_front());
                    if (a_beats == a_mark) a_first_cyc = cyc;
                    a_last_cyc = cyc;
                    a_beats++;
                end
            end
            if (a_done) begin
                a_dones++;
                a_done_cyc = cyc;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            if (b_reg_re | b_mem_re)
                check("b_one_strobe", 64'(b_reg_re & b_mem_re), 64'(0));
            if (b_out_valid) begin
                check("b_beat_expected", 64'(qb.size() != 0), 64'(1));
                if (qb.size() != 0) begin
                    check("b_src",  64'(b_out_src),  64'(qb[0].src));
                    check("b_idx",  64'(b_out_idx),  64'(qb[0].idx));
                    check("b_data", 64'(b_out_data), 64'(qb[0].data));
                end
                if (b_out_ready) begin
                    if (qb.size() != 0) void'(qb.pop_front());
                    b_beats++;
                end
            end
            if (b_done) b_dones++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_regs_a();
        for (int i = 0; i < 32; i++)
            qa.push_back('{src: 1'b0, idx: 6'(i), data: 32'(i * 3)});
    endtask

    task automatic push_mem_a(input int base, input int count);
        int n;
        n = (count > 32) ? 32 : count;
        for (int i = 0; i < n; i++)
            qa.push_back('{src: 1'b1, idx: 6'((base + i) % 32), data: 32'(100 + ((base + i) % 32))});
    endtask

    task automatic start_a(input logic [1:0] s, input logic [4:0] b, input logic [5:0] c);
        a_sel   = s;
        a_base  = b;
        a_count = c;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic finish_a(input string tag, input int d0, input int b0, input int exp_beats);
        int n;
        n = 0;
        while (a_dones == d0 && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_done_seen"}, 64'(a_dones != d0), 64'(1));
        repeat (3) tick();
        check({tag, "_done_count"}, 64'(a_dones - d0), 64'(1));
        check({tag, "_beats"}, 64'(a_beats - b0), 64'(exp_beats));
        check({tag, "_sb_empty"}, 64'(qa.size()), 64'(0));
        check({tag, "_idle"}, 64'(a_busy), 64'(0));
    endtask

    task automatic run_a(input string tag, input logic [1:0] s, input logic [4:0] b,
                         input logic [5:0] c, input int exp_beats);
        int d0, b0;
        d0 = a_dones;
        b0 = a_beats;
        a_mark = a_beats;
        start_a(s, b, c);
        finish_a(tag, d0, b0, exp_beats);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_busy"},      64'(a_busy),      64'(0));
        check({tag, "_done"},      64'(a_done),      64'(0));
        check({tag, "_out_valid"}, 64'(a_out_valid), 64'(0));
        check({tag, "_reg_re"},    64'(a_reg_re),    64'(0));
        check({tag, "_mem_re"},    64'(a_mem_re),    64'(0));
        check({tag, "_out_src"},   64'(a_out_src),   64'(0));
        check({tag, "_out_idx"},   64'(a_out_idx),   64'(0));
        check({tag, "_out_data"},  64'(a_out_data),  64'(0));
        check({tag, "_reg_raddr"}, 64'(a_reg_raddr), 64'(0));
        check({tag, "_mem_raddr"}, 64'(a_mem_raddr), 64'(0));
    endtask

    initial begin
        int d0, b0, n;
        rst = 1'b0;
        a_start = 1'b0; a_sel = 2'b00; a_base = '0; a_count = '0;
        b_start = 1'b0; b_sel = 2'b00; b_base = '0; b_count = '0;

        // reset state
        #12;
        check_a_zero("rst");
        check("rst_b_out_valid", 64'(b_out_valid), 64'(0));
        check("rst_b_busy", 64'(b_busy), 64'(0));
        tick();
        rst = 1'b1;
        repeat (2) tick();

        // GPR dump: strobe latency, first beat latency, back-to-back, done after last beat
        push_regs_a();
        d0 = a_dones; b0 = a_beats; a_mark = a_beats;
        start_a(2'b01, 5'd0, 6'd0);
        check("t33_reg_re_first", 64'(a_reg_re), 64'(1));
        check("t33_raddr_first", 64'(a_reg_raddr), 64'(0));
        check("t33_mem_re_low", 64'(a_mem_re), 64'(0));
        check("t33_busy", 64'(a_busy), 64'(1));
        tick();
        check("t33_valid_early", 64'(a_out_valid), 64'(0));
        tick();
        check("t33_valid_first", 64'(a_out_valid), 64'(1));
        finish_a("t33", d0, b0, 32);
        check("t33_back_to_back", 64'(a_last_cyc - a_first_cyc), 64'(31));
        check("t33_done_after_last", 64'(a_done_cyc - a_last_cyc), 64'(1));

        // memory window wrapping past the top
        push_mem_a(30, 5);
        run_a("t34", 2'b10, 5'd30, 6'd5, 5);

        // both sources under a stalling sink
        a_toggle = 1'b1;
        push_regs_a();
        push_mem_a(7, 2);
        run_a("t35", 2'b11, 5'd7, 6'd2, 34);
        a_toggle = 1'b0;
        tick();

        // zero-length memory dump, and count clamped to the memory size
        run_a("t36_cnt0", 2'b10, 5'd3, 6'd0, 0);
        push_mem_a(5, 40);
        run_a("t_clamp", 2'b10, 5'd5, 6'd40, 32);

        // start while busy is ignored
        push_regs_a();
        d0 = a_dones; b0 = a_beats; a_mark = a_beats;
        start_a(2'b01, 5'd0, 6'd0);
        repeat (4) tick();
        start_a(2'b10, 5'd1, 6'd5);
        finish_a("t36_busy_start", d0, b0, 32);

        // sel=0: done two cycles after start, no beats
        d0 = a_dones; b0 = a_beats;
        start_a(2'b00, 5'd0, 6'd0);
        check("t29_busy_s1", 64'(a_busy), 64'(1));
        check("t29_done_s1", 64'(a_done), 64'(0));
        tick();
        check("t29_busy_s2", 64'(a_busy), 64'(1));
        check("t29_done_s2", 64'(a_done), 64'(1));
        tick();
        check("t29_busy_s3", 64'(a_busy), 64'(0));
        check("t29_done_s3", 64'(a_done), 64'(0));
        check("t29_beats", 64'(a_beats - b0), 64'(0));

        // reset after beat 10 aborts the dump
        push_regs_a();
        d0 = a_dones; b0 = a_beats;
        start_a(2'b01, 5'd0, 6'd0);
        n = 0;
        while ((a_beats - b0) < 11 && n < 200) begin
            tick();
            n++;
        end
        check("t37_reached_beat10", 64'(a_beats - b0), 64'(11));
        #1 rst = 1'b0;
        #1;
        check_a_zero("t37_rst");
        qa.delete();
        b0 = a_beats;
        tick();
        tick();
        rst = 1'b1;
        repeat (5) tick();
        check("t37_no_done", 64'(a_dones - d0), 64'(0));
        check("t37_no_beats", 64'(a_beats - b0), 64'(0));
        push_regs_a();
        run_a("t37_restart", 2'b01, 5'd0, 6'd0, 32);

        // resized instance: 8 GPRs then all 64 memory words
        for (int i = 0; i < 8; i++)
            qb.push_back('{src: 1'b0, idx: 6'(i), data: 32'(i * 3)});
        for (int i = 0; i < 64; i++)
            qb.push_back('{src: 1'b1, idx: 6'(i), data: 32'(100 + i)});
        d0 = b_dones; b0 = b_beats;
        b_sel = 2'b11; b_base = 6'd0; b_count = 7'd64; b_start = 1'b1;
        tick();
        b_start = 1'b0;
        n = 0;
        while (b_dones == d0 && n < 3000) begin
            tick();
            n++;
        end
        repeat (3) tick();
        check("t38_done_count", 64'(b_dones - d0), 64'(1));
        check("t38_beats", 64'(b_beats - b0), 64'(72));
        check("t38_sb_empty", 64'(qb.size()), 64'(0));
        check("t38_idle", 64'(b_busy), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
